// File: rtl/fp_pkg.sv
// Shared FP constants, rounding-mode encodings and the packed single-precision layout.
package fp_pkg;
    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int FP32_BIAS  = 127;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    typedef struct packed {
        logic                  sign;
        logic [FP32_EXP_W-1:0] exp;
        logic [FP32_MAN_W-1:0] frac;
    } fp32_t;
endpackage

// File: rtl/int2fp_pipe_if.sv
// Operand/result handshake bundle for the integer-to-float converter.
interface int2fp_pipe_if #(
    parameter int IN_W  = 32,
    parameter int EXP_W = fp_pkg::FP32_EXP_W,
    parameter int MAN_W = fp_pkg::FP32_MAN_W
);
    logic                   in_valid;
    logic                   in_ready;
    logic [IN_W-1:0]        in_data;
    logic                   in_signed;
    logic [1:0]             in_rm;
    logic                   out_valid;
    logic                   out_ready;
    logic [EXP_W+MAN_W:0]   out_data;
    logic                   out_inexact;

    modport master (output in_valid, in_data, in_signed, in_rm, out_ready,
                    input  in_ready, out_valid, out_data, out_inexact);
    modport slave  (input  in_valid, in_data, in_signed, in_rm, out_ready,
                    output in_ready, out_valid, out_data, out_inexact);
endinterface

// File: rtl/int2fp_pipe_lon.sv
// Leading-one detector plus left barrel shift so the leading one lands in the MSB.
module lead_one_norm #(
    parameter  int W  = 32,
    localparam int PW = $clog2(W)
) (
    input  logic [W-1:0]  mag_i,
    output logic [PW-1:0] pos_o,
    output logic [W-1:0]  norm_o
);
    always_comb begin
        pos_o = '0;
        for (int i = 0; i < W; i++)
            if (mag_i[i]) pos_o = PW'(i);
        norm_o = mag_i << (PW'(W-1) - pos_o);
    end
endmodule

// File: rtl/int2fp_pipe.sv
// Three-stage integer-to-float converter: sign/magnitude, normalise, round/pack.
module int2fp_pipe import fp_pkg::*; #(
    parameter int IN_W  = 32,
    parameter int EXP_W = FP32_EXP_W,
    parameter int MAN_W = FP32_MAN_W,
    parameter int BIAS  = FP32_BIAS
) (
    input logic           clk,
    input logic           rst_n,
    int2fp_pipe_if.slave  io
);
    localparam int STAGES = 3;
    localparam int PW     = $clog2(IN_W);
    localparam int EXT_W  = IN_W + MAN_W + 1;

    if (IN_W + BIAS >= 2**EXP_W - 1) begin : g_illegal
        $error("int2fp_pipe: IN_W + BIAS must be below 2**EXP_W - 1");
    end

    logic [STAGES:1] vld_q;
    logic            rdy1, rdy2, rdy3;

    // Ready ripples back from the consumer so a full pipe still streams.
    assign rdy3        = ~vld_q[3] | io.out_ready;
    assign rdy2        = ~vld_q[2] | rdy3;
    assign rdy1        = ~vld_q[1] | rdy2;
    assign io.in_ready = rdy1;

    logic            s1_sign_d, s1_sign_q;
    logic [IN_W-1:0] s1_mag_d, s1_mag_q;
    logic [1:0]      s1_rm_q;

    assign s1_sign_d = io.in_signed & io.in_data[IN_W-1];
    assign s1_mag_d  = s1_sign_d ? -io.in_data : io.in_data;

    logic [PW-1:0]    lon_pos;
    logic [IN_W-1:0]  lon_norm;
    logic             s2_sign_q;
    logic [1:0]       s2_rm_q;
    logic [IN_W-1:0]  s2_norm_q;
    logic [EXP_W-1:0] s2_exp_d, s2_exp_q;

    lead_one_norm #(.W(IN_W)) u_lon (
        .mag_i  (s1_mag_q),
        .pos_o  (lon_pos),
        .norm_o (lon_norm)
    );

    // Legality bound guarantees exp (even after a rounding carry) fits in EXP_W bits.
    assign s2_exp_d = EXP_W'(lon_pos) + EXP_W'(BIAS);

    logic [EXT_W-1:0]     ext;
    logic [MAN_W-1:0]     frac, frac_r;
    logic                 g_bit, s_bit, nx, up, carry, zero;
    logic [EXP_W-1:0]     exp_r;
    logic [EXP_W+MAN_W:0] s3_data_d, s3_data_q;
    logic                 s3_nx_d, s3_nx_q;

    always_comb begin
        ext   = {s2_norm_q[IN_W-2:0], (MAN_W+2)'(0)};
        frac  = ext[EXT_W-1 -: MAN_W];
        g_bit = ext[EXT_W-1-MAN_W];
        s_bit = |ext[EXT_W-2-MAN_W:0];
        nx    = g_bit | s_bit;
        // Normalised MSB is clear only when the operand was zero.
        zero  = ~s2_norm_q[IN_W-1];
        unique case (s2_rm_q)
            RM_RNE:  up = g_bit & (s_bit | frac[0]);
            RM_RTZ:  up = 1'b0;
            RM_RUP:  up = nx & ~s2_sign_q;
            default: up = nx & s2_sign_q;
        endcase
        {carry, frac_r} = {1'b0, frac} + (MAN_W+1)'(up);
        exp_r     = s2_exp_q + EXP_W'(carry);
        s3_data_d = zero ? '0 : {s2_sign_q, exp_r, frac_r};
        s3_nx_d   = ~zero & nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            s1_sign_q <= 1'b0;
            s1_mag_q  <= '0;
            s1_rm_q   <= '0;
            s2_sign_q <= 1'b0;
            s2_rm_q   <= '0;
            s2_norm_q <= '0;
            s2_exp_q  <= '0;
            s3_data_q <= '0;
            s3_nx_q   <= 1'b0;
        end else begin
            if (rdy1) vld_q[1] <= io.in_valid;
            if (rdy2) vld_q[2] <= vld_q[1];
            if (rdy3) vld_q[3] <= vld_q[2];
            if (rdy1 & io.in_valid) begin
                s1_sign_q <= s1_sign_d;
                s1_mag_q  <= s1_mag_d;
                s1_rm_q   <= io.in_rm;
            end
            if (rdy2 & vld_q[1]) begin
                s2_sign_q <= s1_sign_q;
                s2_rm_q   <= s1_rm_q;
                s2_norm_q <= lon_norm;
                s2_exp_q  <= s2_exp_d;
            end
            if (rdy3 & vld_q[2]) begin
                s3_data_q <= s3_data_d;
                s3_nx_q   <= s3_nx_d;
            end
        end
    end

    assign io.out_valid   = vld_q[3];
    assign io.out_data    = s3_data_q;
    assign io.out_inexact = s3_nx_q;
endmodule

// File: tb/tb_int2fp_pipe.sv
// Directed-vector bench for int2fp_pipe: table sweep, streaming, backpressure, mid-flight reset.
module tb_int2fp_pipe;
    import fp_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int2fp_pipe_if bus ();
    int2fp_pipe dut (.clk(clk), .rst_n(rst_n), .io(bus));

    typedef struct {
        logic [31:0] d;
        logic        s;
        logic [1:0]  rm;
        logic [31:0] e;
        logic        nx;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];
    int   total = 0;
    int   bad   = 0;
    int   bp_idx [5] = '{0, 4, 6, 14, 15};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bus.in_valid  = 1'b1;
        bus.in_data   = v.d;
        bus.in_signed = v.s;
        bus.in_rm     = v.rm;
    endtask

    task automatic set(input int i, input logic [31:0] d, input logic s, input logic [1:0] rm,
                       input logic [31:0] e, input logic nx);
        tbl[i].d = d; tbl[i].s = s; tbl[i].rm = rm; tbl[i].e = e; tbl[i].nx = nx;
    endtask

    // One op in isolation: checks acceptance, 3-cycle latency, value and NX.
    task automatic single(input vec_t v, input string name);
        int lat;
        drive(v);
        chk({name, "_rdy"}, 32'(bus.in_ready), 32'd1);
        tick;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            tick;
            lat++;
        end
        chk({name, "_lat"}, 32'(lat), 32'd3);
        chk({name, "_data"}, bus.out_data, v.e);
        chk({name, "_nx"}, 32'(bus.out_inexact), 32'(v.nx));
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set( 0, 32'h00000001, 1, RM_RNE, 32'h3F800000, 0);
        set( 1, 32'h00000000, 1, RM_RNE, 32'h00000000, 0);
        set( 2, 32'h00000000, 0, RM_RUP, 32'h00000000, 0);
        set( 3, 32'h00000000, 1, RM_RDN, 32'h00000000, 0);
        set( 4, 32'hFFFFFFFF, 1, RM_RNE, 32'hBF800000, 0);
        set( 5, 32'h80000000, 1, RM_RNE, 32'hCF000000, 0);
        set( 6, 32'h80000000, 0, RM_RNE, 32'h4F000000, 0);
        set( 7, 32'hFFFFFFFF, 0, RM_RNE, 32'h4F800000, 1);
        set( 8, 32'hFFFFFFFF, 0, RM_RTZ, 32'h4F7FFFFF, 1);
        set( 9, 32'h01000001, 1, RM_RNE, 32'h4B800000, 1);
        set(10, 32'h01000001, 1, RM_RUP, 32'h4B800001, 1);
        set(11, 32'h01000003, 1, RM_RNE, 32'h4B800002, 1);
        set(12, 32'hFEFFFFFF, 1, RM_RDN, 32'hCB800001, 1);
        set(13, 32'hFEFFFFFF, 1, RM_RUP, 32'hCB800000, 1);
        set(14, 32'h00000005, 1, RM_RTZ, 32'h40A00000, 0);
        set(15, 32'hFFFFFFFB, 1, RM_RNE, 32'hC0A00000, 0);
        set(16, 32'h7FFFFFFF, 1, RM_RTZ, 32'h4EFFFFFF, 1);
        set(17, 32'h01000001, 1, RM_RDN, 32'h4B800000, 1);
        set(18, 32'hFFFFFFFF, 0, RM_RDN, 32'h4F7FFFFF, 1);
        set(19, 32'hFEFFFFFF, 1, RM_RTZ, 32'hCB800000, 1);
        set(20, 32'h00FFFFFF, 0, RM_RNE, 32'h4B7FFFFF, 0);
        set(21, 32'hFFFFFFFF, 0, RM_RUP, 32'h4F800000, 1);

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_signed = 1'b0;
        bus.in_rm     = RM_RNE;
        bus.out_ready = 1'b1;

        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_nx", 32'(bus.out_inexact), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < NV; i++) single(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back stream at full throughput.
        fork
            begin
                for (int i = 0; i < NV; i++) begin
                    drive(tbl[i]);
                    tick;
                end
                bus.in_valid = 1'b0;
            end
            begin
                int w;
                w = 0;
                while (!bus.out_valid && w < 10) begin
                    tick;
                    w++;
                end
                for (int k = 0; k < NV; k++) begin
                    chk($sformatf("str%0d_valid", k), 32'(bus.out_valid), 32'd1);
                    chk($sformatf("str%0d_data", k), bus.out_data, tbl[k].e);
                    chk($sformatf("str%0d_nx", k), 32'(bus.out_inexact), 32'(tbl[k].nx));
                    tick;
                end
            end
        join
        chk("str_drain", 32'(bus.out_valid), 32'd0);

        // Backpressure: offer 5 ops with consumer stalled; only 3 fit.
        begin
            int j;
            bus.out_ready = 1'b0;
            j = 0;
            for (int c = 0; c < 8; c++) begin
                if (j < 5) drive(tbl[bp_idx[j]]);
                if (bus.in_valid && bus.in_ready) j++;
                tick;
            end
            bus.in_valid = 1'b0;
            chk("bp_accepted", 32'(j), 32'd3);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            for (int c = 0; c < 2; c++) begin
                chk($sformatf("bp_hold%0d_valid", c), 32'(bus.out_valid), 32'd1);
                chk($sformatf("bp_hold%0d_data", c), bus.out_data, tbl[bp_idx[0]].e);
                tick;
            end
            bus.out_ready = 1'b1;
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("bp_out%0d_valid", k), 32'(bus.out_valid), 32'd1);
                chk($sformatf("bp_out%0d_data", k), bus.out_data, tbl[bp_idx[k]].e);
                tick;
            end
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("bp_nodup%0d", c), 32'(bus.out_valid), 32'd0);
                tick;
            end
        end

        // Reset with a full pipe: output drops at once, nothing stale afterwards.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(tbl[bp_idx[k]]);
            tick;
        end
        bus.in_valid = 1'b0;
        tick;
        chk("mr_full_valid", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_async_valid", 32'(bus.out_valid), 32'd0);
        chk("mr_async_data", bus.out_data, 32'd0);
        tick;
        tick;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick;
        chk("mr_in_ready", 32'(bus.in_ready), 32'd1);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("mr_stale%0d", c), 32'(bus.out_valid), 32'd0);
            tick;
        end
        single(tbl[12], "mr_first");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
